// File: rtl/fifo_pkg.sv
// Shared definitions for the single-entry FIFO write arbiter and any
// read-side schedulers that reuse its round-robin picker.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 32;
  localparam int OWNER_W_MAX        = 3;

  // Ceiling log2 with a floor of 1, so N=2 still gets a 1-bit id.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [OWNER_W_MAX-1:0] owner_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate valid so ptr lands on bit 0, priority-encode,
// then rotate the index back. Out-of-range pointers are treated as 0.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] p;
  logic [N-1:0]   rot;
  logic [IDW-1:0] enc;
  logic [IDW:0]   back;

  always_comb begin
    p   = (int'(ptr) < N) ? ptr : '0;
    rot = (valid >> p) | (valid << ((IDW+1)'(N) - {1'b0, p}));
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDW'(i);
    end
    back = {1'b0, p} + {1'b0, enc};
    if (back >= (IDW+1)'(N)) back = back - (IDW+1)'(N);
    idx = back[IDW-1:0];
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single-entry FIFO; snoops the
// consumer's read strobe to report which requester owns the buffered entry.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int N     = 2,
  parameter int IDW   = clog2(N)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  input  logic               fifo_full,
  input  logic               fifo_rd,
  output logic               fifo_wr,
  output logic [WIDTH-1:0]   fifo_din,
  output logic               owner_valid,
  output logic [IDW-1:0]     owner_id
);

  // Handshake: requester i transfers when req_valid[i] && req_ready[i]. Valid
  // and data are held stable until ready and never withdrawn; ready is a
  // function of valid, fifo_full and rr_ptr only, never of data.
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner_q;
  logic           owner_valid_q;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           grant;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  assign grant   = resetn && !fifo_full && pick_any;
  assign fifo_wr = grant;

  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant && (pick_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        fifo_din     = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A write and a read never coincide on the full single entry, so a write
  // simply takes precedence over the read snoop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr        <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
    end else if (grant) begin
      rr_ptr        <= (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
      owner_q       <= pick_idx;
      owner_valid_q <= 1'b1;
    end else if (fifo_rd && owner_valid_q) begin
      owner_valid_q <= 1'b0;
    end
  end

  assign owner_valid = owner_valid_q;
  assign owner_id    = owner_valid_q ? owner_q : '0;

  a_owner_tracks_full: assert property (@(posedge clk) disable iff (!resetn)
    owner_valid_q == fifo_full);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: N=2 and N=3 instances, each with a one-entry
// FIFO model, checked against a queue-based round-robin reference.
module tb_fifo_wr_arbiter;

  localparam int W = 32;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]     req_valid = '0;
  logic [2*W-1:0] req_data  = '0;
  logic [1:0]     req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_rd   = 1'b0;
  logic           fifo_wr;
  logic [W-1:0]   fifo_din;
  logic [W-1:0]   fifo_q    = '0;
  logic           owner_valid;
  logic [0:0]     owner_id;

  logic [2:0]     req_valid3 = '0;
  logic [3*W-1:0] req_data3  = '0;
  logic [2:0]     req_ready3;
  logic           fifo_full3 = 1'b0;
  logic           fifo_rd3   = 1'b0;
  logic           fifo_wr3;
  logic [W-1:0]   fifo_din3;
  logic [W-1:0]   fifo_q3    = '0;
  logic           owner_valid3;
  logic [1:0]     owner_id3;

  fifo_wr_arbiter #(.WIDTH(W), .N(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_rd(fifo_rd),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .owner_valid(owner_valid),
    .owner_id(owner_id)
  );

  fifo_wr_arbiter #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .fifo_full(fifo_full3), .fifo_rd(fifo_rd3),
    .fifo_wr(fifo_wr3), .fifo_din(fifo_din3), .owner_valid(owner_valid3),
    .owner_id(owner_id3)
  );

  // Single-entry FIFOs sharing the arbiter reset.
  always @(posedge clk) begin
    if (!resetn) fifo_full <= 1'b0;
    else if (fifo_wr) begin fifo_full <= 1'b1; fifo_q <= fifo_din; end
    else if (fifo_rd) fifo_full <= 1'b0;
  end

  always @(posedge clk) begin
    if (!resetn) fifo_full3 <= 1'b0;
    else if (fifo_wr3) begin fifo_full3 <= 1'b1; fifo_q3 <= fifo_din3; end
    else if (fifo_rd3) fifo_full3 <= 1'b0;
  end

  // Reference model: pointer as an integer, FIFO contents and owners as queues.
  int           m2_ptr = 0;
  int           m3_ptr = 0;
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] exp3_q[$];
  int           own2_q[$];
  int           own3_q[$];
  int           e2_g, e3_g;
  logic [1:0]   e2_ready;
  logic [2:0]   e3_ready;
  logic [W-1:0] e2_din, e3_din;

  function automatic int pick(input logic [7:0] v, input int ptr, input int n);
    logic [7:0] s;
    for (int k = 0; k < n; k++) begin
      s = v >> ((ptr + k) % n);
      if (s[0]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic calc2();
    logic [2*W-1:0] sh;
    e2_g     = (resetn && exp2_q.size() == 0) ? pick({6'b0, req_valid}, m2_ptr, 2) : -1;
    e2_ready = (e2_g >= 0) ? 2'(32'd1 << e2_g) : 2'b00;
    sh       = req_data >> (((e2_g >= 0) ? e2_g : 0) * W);
    e2_din   = (e2_g >= 0) ? sh[W-1:0] : '0;
  endtask

  task automatic calc3();
    logic [3*W-1:0] sh;
    e3_g     = (resetn && exp3_q.size() == 0) ? pick({5'b0, req_valid3}, m3_ptr, 3) : -1;
    e3_ready = (e3_g >= 0) ? 3'(32'd1 << e3_g) : 3'b000;
    sh       = req_data3 >> (((e3_g >= 0) ? e3_g : 0) * W);
    e3_din   = (e3_g >= 0) ? sh[W-1:0] : '0;
  endtask

  task automatic tick();
    calc2();
    calc3();
    @(posedge clk);
    if (!resetn) begin
      m2_ptr = 0; exp2_q.delete(); own2_q.delete();
      m3_ptr = 0; exp3_q.delete(); own3_q.delete();
    end else begin
      if (e2_g >= 0) begin
        m2_ptr = (e2_g + 1) % 2; exp2_q.push_back(e2_din); own2_q.push_back(e2_g);
      end else if (fifo_rd && exp2_q.size() != 0) begin
        void'(exp2_q.pop_front()); void'(own2_q.pop_front());
      end
      if (e3_g >= 0) begin
        m3_ptr = (e3_g + 1) % 3; exp3_q.push_back(e3_din); own3_q.push_back(e3_g);
      end else if (fifo_rd3 && exp3_q.size() != 0) begin
        void'(exp3_q.pop_front()); void'(own3_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0; req_valid3 = '0;
    fifo_rd = 1'b1; fifo_rd3 = 1'b1;
    tick();
    fifo_rd = 1'b0; fifo_rd3 = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 2'b11; req_data = {$urandom, $urandom}; fifo_rd = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (req_ready !== 2'b00 || fifo_wr !== 1'b0 || fifo_din !== '0)
        $display("FAIL reset_outputs ready=%b wr=%b din=%h need 00/0/0", req_ready, fifo_wr, fifo_din);
      else n_pass++;
      n_chk++; if (owner_valid !== 1'b0 || owner_id !== 1'b0)
        $display("FAIL reset_owner valid=%b id=%0d need 0/0", owner_valid, owner_id);
      else n_pass++;
      tick();
    end
    resetn = 1'b1;
    #1;
    n_chk++; if (req_ready !== 2'b01 || fifo_wr !== 1'b1)
      $display("FAIL reset_first_grant ready=%b wr=%b need 01/1", req_ready, fifo_wr);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    #1;
    n_chk++; if (owner_valid !== 1'b1 || owner_id !== 1'b0)
      $display("FAIL reset_first_owner valid=%b id=%0d need 1/0", owner_valid, owner_id);
    else n_pass++;
    drain();
  endtask

  task automatic test_single();
    reset_all();
    req_valid = 2'b01; req_data = {$urandom, 32'hA5A5_A5A5};
    #1;
    n_chk++; if (req_ready !== 2'b01 || fifo_wr !== 1'b1 || fifo_din !== 32'hA5A5_A5A5)
      $display("FAIL single_grant ready=%b wr=%b din=%h need 01/1/a5a5a5a5", req_ready, fifo_wr, fifo_din);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    #1;
    n_chk++; if (owner_valid !== 1'b1 || owner_id !== 1'b0 || dut.rr_ptr !== 1'b1)
      $display("FAIL single_owner valid=%b id=%0d ptr=%0d need 1/0/1", owner_valid, owner_id, dut.rr_ptr);
    else n_pass++;
    drain();
    #1;
    n_chk++; if (owner_valid !== 1'b0)
      $display("FAIL single_read owner_valid=%b need 0", owner_valid);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    reset_all();
    req_valid = 2'b11; req_data = {$urandom, $urandom};
    for (int c = 0; c < 8; c++) begin
      fifo_rd = (exp2_q.size() != 0);
      #1;
      exp_rdy = (c % 2 != 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_chk++; if (req_ready !== exp_rdy)
        $display("FAIL contention_ready cycle=%0d got=%b need=%b", c, req_ready, exp_rdy);
      else n_pass++;
      if (c % 2 != 0) begin
        n_chk++; if (owner_valid !== 1'b1 || int'(owner_id) !== ((c - 1) / 2) % 2)
          $display("FAIL contention_owner cycle=%0d valid=%b id=%0d need 1/%0d", c, owner_valid, owner_id, ((c - 1) / 2) % 2);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full_backpressure();
    reset_all();
    req_valid = 2'b01; req_data = {$urandom, $urandom};
    tick();
    req_valid = 2'b10; fifo_rd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (req_ready !== 2'b00 || dut.rr_ptr !== 1'b1)
        $display("FAIL full_hold cycle=%0d ready=%b ptr=%0d need 00/1", c, req_ready, dut.rr_ptr);
      else n_pass++;
      tick();
    end
    fifo_rd = 1'b1;
    #1;
    n_chk++; if (req_ready !== 2'b00)
      $display("FAIL full_read_cycle ready=%b need 00", req_ready);
    else n_pass++;
    tick();
    fifo_rd = 1'b0;
    #1;
    n_chk++; if (owner_valid !== 1'b0 || req_ready !== 2'b10 || fifo_wr !== 1'b1)
      $display("FAIL full_release valid=%b ready=%b wr=%b need 0/10/1", owner_valid, req_ready, fifo_wr);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    #1;
    n_chk++; if (owner_valid !== 1'b1 || owner_id !== 1'b1)
      $display("FAIL full_new_owner valid=%b id=%0d need 1/1", owner_valid, owner_id);
    else n_pass++;
    drain();
  endtask

  task automatic test_wrap_n3();
    reset_all();
    req_valid3 = 3'b010; req_data3 = {$urandom, $urandom, $urandom};
    tick();
    req_valid3 = 3'b000;
    #1;
    n_chk++; if (dut3.rr_ptr !== 2'd2)
      $display("FAIL wrap_setup ptr=%0d need 2", dut3.rr_ptr);
    else n_pass++;
    drain();
    req_valid3 = 3'b011;
    #1;
    n_chk++; if (req_ready3 !== 3'b001 || fifo_din3 !== req_data3[W-1:0])
      $display("FAIL wrap_grant ready=%b din=%h need 001/%h", req_ready3, fifo_din3, req_data3[W-1:0]);
    else n_pass++;
    tick();
    req_valid3 = 3'b000;
    #1;
    n_chk++; if (dut3.rr_ptr !== 2'd1 || owner_valid3 !== 1'b1 || owner_id3 !== 2'd0)
      $display("FAIL wrap_after ptr=%0d valid=%b id=%0d need 1/1/0", dut3.rr_ptr, owner_valid3, owner_id3);
    else n_pass++;
    drain();
  endtask

  task automatic test_mid_reset();
    reset_all();
    req_valid = 2'b01; req_data = {$urandom, $urandom};
    tick();
    req_valid = 2'b11;
    #1;
    n_chk++; if (owner_valid !== 1'b1)
      $display("FAIL midreset_setup owner_valid=%b need 1", owner_valid);
    else n_pass++;
    resetn = 1'b0; fifo_rd = 1'b1;
    #1;
    n_chk++; if (req_ready !== 2'b00 || fifo_wr !== 1'b0)
      $display("FAIL midreset_forced ready=%b wr=%b need 00/0", req_ready, fifo_wr);
    else n_pass++;
    tick();
    resetn = 1'b1; fifo_rd = 1'b0; req_valid = 2'b00;
    #1;
    n_chk++; if (owner_valid !== 1'b0 || dut.rr_ptr !== 1'b0)
      $display("FAIL midreset_cleared valid=%b ptr=%0d need 0/0", owner_valid, dut.rr_ptr);
    else n_pass++;
    req_valid = 2'b11;
    #1;
    n_chk++; if (req_ready !== 2'b01)
      $display("FAIL midreset_regrant ready=%b need 01", req_ready);
    else n_pass++;
    tick();
    drain();
  endtask

  // Requesters hold valid/data until granted, then may raise a new request.
  task automatic refresh_reqs();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] m;
      m = 2'(32'd1 << i);
      if (e2_g == i) req_valid = req_valid & ~m;
      else if ((req_valid & m) == 2'b00 && $urandom_range(0, 1) == 1) begin
        req_valid = req_valid | m;
        req_data  = (req_data & ~({{W{1'b0}}, {W{1'b1}}} << (i * W)))
                  | ({{W{1'b0}}, W'($urandom)} << (i * W));
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] m;
      m = 3'(32'd1 << i);
      if (e3_g == i) req_valid3 = req_valid3 & ~m;
      else if ((req_valid3 & m) == 3'b000 && $urandom_range(0, 1) == 1) begin
        req_valid3 = req_valid3 | m;
        req_data3  = (req_data3 & ~({{2*W{1'b0}}, {W{1'b1}}} << (i * W)))
                   | ({{2*W{1'b0}}, W'($urandom)} << (i * W));
      end
    end
  endtask

  task automatic test_random();
    reset_all();
    req_valid = '0; req_valid3 = '0;
    for (int c = 0; c < 400; c++) begin
      fifo_rd  = (exp2_q.size() != 0) && ($urandom_range(0, 2) != 0);
      fifo_rd3 = (exp3_q.size() != 0) && ($urandom_range(0, 2) != 0);
      #1;
      calc2();
      calc3();
      n_chk++; if (req_ready !== e2_ready || fifo_wr !== (e2_g >= 0) || fifo_din !== e2_din)
        $display("FAIL rand2_grant cycle=%0d ready=%b wr=%b din=%h need %b/%0d/%h", c, req_ready, fifo_wr, fifo_din, e2_ready, e2_g >= 0, e2_din);
      else n_pass++;
      n_chk++; if (owner_valid !== (own2_q.size() != 0) || int'(owner_id) !== ((own2_q.size() != 0) ? own2_q[0] : 0))
        $display("FAIL rand2_owner cycle=%0d valid=%b id=%0d", c, owner_valid, owner_id);
      else n_pass++;
      n_chk++; if (int'(dut.rr_ptr) !== m2_ptr)
        $display("FAIL rand2_ptr cycle=%0d got=%0d need=%0d", c, dut.rr_ptr, m2_ptr);
      else n_pass++;
      n_chk++; if (req_ready3 !== e3_ready || fifo_wr3 !== (e3_g >= 0) || fifo_din3 !== e3_din)
        $display("FAIL rand3_grant cycle=%0d ready=%b wr=%b din=%h need %b/%0d/%h", c, req_ready3, fifo_wr3, fifo_din3, e3_ready, e3_g >= 0, e3_din);
      else n_pass++;
      n_chk++; if (owner_valid3 !== (own3_q.size() != 0) || int'(owner_id3) !== ((own3_q.size() != 0) ? own3_q[0] : 0))
        $display("FAIL rand3_owner cycle=%0d valid=%b id=%0d", c, owner_valid3, owner_id3);
      else n_pass++;
      n_chk++; if (int'(dut3.rr_ptr) !== m3_ptr)
        $display("FAIL rand3_ptr cycle=%0d got=%0d need=%0d", c, dut3.rr_ptr, m3_ptr);
      else n_pass++;
      if (fifo_rd && exp2_q.size() != 0) begin
        n_chk++; if (fifo_q !== exp2_q[0])
          $display("FAIL rand2_data cycle=%0d got=%h need=%h", c, fifo_q, exp2_q[0]);
        else n_pass++;
      end
      if (fifo_rd3 && exp3_q.size() != 0) begin
        n_chk++; if (fifo_q3 !== exp3_q[0])
          $display("FAIL rand3_data cycle=%0d got=%h need=%h", c, fifo_q3, exp3_q[0]);
        else n_pass++;
      end
      tick();
      refresh_reqs();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full_backpressure();
    test_wrap_n3();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
